// File: rtl/grf_wr_arbiter_pkg.sv
// Shared GRF write-port types and widths.
// Used by the write arbiter and its aux result FIFO.
package grf_wr_arbiter_pkg;

   localparam int GRF_AW = 5;
   localparam int WORD   = 32;

   localparam logic [GRF_AW-1:0] REG_ZERO = '0;

   typedef struct packed {
      logic [GRF_AW-1:0] a3;
      logic [WORD-1:0]   wd;
      logic [WORD-1:0]   pc;
   } grf_wr_t;

endpackage

// File: rtl/grf_arb_fifo.sv
// In-order aux result FIFO with per-entry kill bits.
// Kill-by-address port and parallel address compares for hazard lookup.
module grf_arb_fifo
   import grf_wr_arbiter_pkg::*;
#(
   parameter int DEPTH = 4,
   localparam int PW   = $clog2(DEPTH),
   localparam int CW   = $clog2(DEPTH + 1)
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              i_push,
   input  grf_wr_t           i_push_ent,
   input  logic              i_pop,
   input  logic              i_kill_en,
   input  logic [GRF_AW-1:0] i_kill_a3,
   input  logic [GRF_AW-1:0] i_cmp_a1,
   input  logic [GRF_AW-1:0] i_cmp_a2,
   output grf_wr_t           o_head,
   output logic              o_head_kill,
   output logic [CW-1:0]     o_cnt,
   output logic [DEPTH-1:0]  o_hit1,
   output logic [DEPTH-1:0]  o_hit2
);

   grf_wr_t          r_ent [DEPTH];
   logic [DEPTH-1:0] r_kill;
   logic [PW-1:0]    r_rd_ptr;
   logic [PW-1:0]    r_wr_ptr;
   logic [CW-1:0]    r_cnt;

   logic [DEPTH-1:0] w_live;
   logic [DEPTH-1:0] w_kill_nxt;
   logic [PW-1:0]    w_off;

   // Occupancy map, address compares and next kill bits.
   always_comb begin
      w_live     = '0;
      o_hit1     = '0;
      o_hit2     = '0;
      w_off      = '0;
      w_kill_nxt = r_kill;
      for (int i = 0; i < DEPTH; i++) begin
         w_off     = PW'(i) - r_rd_ptr;
         w_live[i] = (CW'(w_off) < r_cnt);
         o_hit1[i] = w_live[i] & ~r_kill[i] & (r_ent[i].a3 == i_cmp_a1);
         o_hit2[i] = w_live[i] & ~r_kill[i] & (r_ent[i].a3 == i_cmp_a2);
         if (i_kill_en && w_live[i] && (r_ent[i].a3 == i_kill_a3))
            w_kill_nxt[i] = 1'b1;
      end
      if (i_push)
         w_kill_nxt[r_wr_ptr] = 1'b0;
   end

   // Entry payload storage; written only on push.
   always_ff @(posedge clk) begin
      if (i_push)
         r_ent[r_wr_ptr] <= i_push_ent;
   end

   // Pointers, count and kill bits.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_rd_ptr <= '0;
         r_wr_ptr <= '0;
         r_cnt    <= '0;
         r_kill   <= '0;
      end else begin
         r_kill <= w_kill_nxt;
         if (i_push)
            r_wr_ptr <= r_wr_ptr + PW'(1);
         if (i_pop)
            r_rd_ptr <= r_rd_ptr + PW'(1);
         if (i_push && !i_pop)
            r_cnt <= r_cnt + CW'(1);
         else if (!i_push && i_pop)
            r_cnt <= r_cnt - CW'(1);
      end
   end

   assign o_head      = r_ent[r_rd_ptr];
   assign o_head_kill = r_kill[r_rd_ptr];
   assign o_cnt       = r_cnt;

endmodule

// File: rtl/grf_wr_arbiter.sv
// GRF write-port arbiter: pipe writeback wins, aux results drain when idle.
// Also reports pending aux writes and requests a W bubble on starvation.
module grf_wr_arbiter
   import grf_wr_arbiter_pkg::*;
#(
   parameter int DEPTH    = 4,
   parameter int MAX_WAIT = 8
) (
   input  logic                       clk,
   input  logic                       reset,
   input  logic                       pipe_we,
   input  logic [GRF_AW-1:0]          pipe_a3,
   input  logic [WORD-1:0]            pipe_wd,
   input  logic [WORD-1:0]            pipe_pc,
   input  logic                       aux_valid,
   output logic                       aux_ready,
   input  logic [GRF_AW-1:0]          aux_a3,
   input  logic [WORD-1:0]            aux_wd,
   input  logic [WORD-1:0]            aux_pc,
   input  logic [GRF_AW-1:0]          rd_a1,
   input  logic [GRF_AW-1:0]          rd_a2,
   output logic                       pend_hit1,
   output logic                       pend_hit2,
   output logic                       stall_req,
   output logic [GRF_AW-1:0]          grf_a3,
   output logic [WORD-1:0]            grf_wd,
   output logic [WORD-1:0]            grf_pc,
   output logic [$clog2(DEPTH+1)-1:0] fifo_cnt
);

   localparam int CW = $clog2(DEPTH + 1);
   localparam int WW = $clog2(MAX_WAIT + 1);

   logic             w_busy;
   logic             w_nonempty;
   logic             w_push;
   logic             w_pop;
   logic             w_kill_en;
   logic             w_head_kill;
   logic [CW-1:0]    w_cnt;
   logic [DEPTH-1:0] w_hit1;
   logic [DEPTH-1:0] w_hit2;
   grf_wr_t          w_head;
   grf_wr_t          w_push_ent;
   logic [WW-1:0]    r_wait;

   assign w_busy     = pipe_we & (pipe_a3 != REG_ZERO);
   assign w_nonempty = (w_cnt != '0);
   assign aux_ready  = ~reset & (w_cnt < CW'(DEPTH));
   assign w_push     = aux_valid & aux_ready & (aux_a3 != REG_ZERO);
   assign w_pop      = ~reset & ~w_busy & w_nonempty;
   assign w_kill_en  = ~reset & w_busy;
   assign w_push_ent = '{a3: aux_a3, wd: aux_wd, pc: aux_pc};

   grf_arb_fifo #(
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk         (clk),
      .reset       (reset),
      .i_push      (w_push),
      .i_push_ent  (w_push_ent),
      .i_pop       (w_pop),
      .i_kill_en   (w_kill_en),
      .i_kill_a3   (pipe_a3),
      .i_cmp_a1    (rd_a1),
      .i_cmp_a2    (rd_a2),
      .o_head      (w_head),
      .o_head_kill (w_head_kill),
      .o_cnt       (w_cnt),
      .o_hit1      (w_hit1),
      .o_hit2      (w_hit2)
   );

   // Write-port select: pipe, then live FIFO head, else no write.
   always_comb begin
      grf_a3 = REG_ZERO;
      grf_wd = '0;
      grf_pc = '0;
      if (reset) begin
         grf_a3 = REG_ZERO;
      end else if (w_busy) begin
         grf_a3 = pipe_a3;
         grf_wd = pipe_wd;
         grf_pc = pipe_pc;
      end else if (w_pop) begin
         grf_a3 = w_head_kill ? REG_ZERO : w_head.a3;
         grf_wd = w_head.wd;
         grf_pc = w_head.pc;
      end
   end

   // Consecutive cycles the FIFO head was blocked by the pipe.
   always_ff @(posedge clk) begin
      if (reset)
         r_wait <= '0;
      else if (w_pop || !w_nonempty)
         r_wait <= '0;
      else if (w_busy && (r_wait < WW'(MAX_WAIT)))
         r_wait <= r_wait + WW'(1);
   end

   assign stall_req = ~reset & (r_wait >= WW'(MAX_WAIT));
   assign pend_hit1 = ~reset & (rd_a1 != REG_ZERO) & (|w_hit1);
   assign pend_hit2 = ~reset & (rd_a2 != REG_ZERO) & (|w_hit2);
   assign fifo_cnt  = w_cnt;

endmodule

// File: tb/tb_grf_wr_arbiter.sv
// Directed bench for grf_wr_arbiter.
// Inputs change just after the rising edge; outputs sampled 1ns later.
module tb_grf_wr_arbiter;

   logic        clk;
   logic        reset;
   logic        pipe_we;
   logic [4:0]  pipe_a3;
   logic [31:0] pipe_wd;
   logic [31:0] pipe_pc;
   logic        aux_valid;
   logic        aux_ready;
   logic [4:0]  aux_a3;
   logic [31:0] aux_wd;
   logic [31:0] aux_pc;
   logic [4:0]  rd_a1;
   logic [4:0]  rd_a2;
   logic        pend_hit1;
   logic        pend_hit2;
   logic        stall_req;
   logic [4:0]  grf_a3;
   logic [31:0] grf_wd;
   logic [31:0] grf_pc;
   logic [2:0]  fifo_cnt;

   int n_vec;
   int n_err;

   grf_wr_arbiter #(
      .DEPTH    (4),
      .MAX_WAIT (8)
   ) dut (
      .clk       (clk),
      .reset     (reset),
      .pipe_we   (pipe_we),
      .pipe_a3   (pipe_a3),
      .pipe_wd   (pipe_wd),
      .pipe_pc   (pipe_pc),
      .aux_valid (aux_valid),
      .aux_ready (aux_ready),
      .aux_a3    (aux_a3),
      .aux_wd    (aux_wd),
      .aux_pc    (aux_pc),
      .rd_a1     (rd_a1),
      .rd_a2     (rd_a2),
      .pend_hit1 (pend_hit1),
      .pend_hit2 (pend_hit2),
      .stall_req (stall_req),
      .grf_a3    (grf_a3),
      .grf_wd    (grf_wd),
      .grf_pc    (grf_pc),
      .fifo_cnt  (fifo_cnt)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      n_vec++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h want %0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic aux(input logic v, input logic [4:0] a);
      aux_valid = v;
      aux_a3    = a;
      aux_wd    = 32'h100 + 32'(a);
      aux_pc    = 32'h1000 + {25'd0, a, 2'b00};
   endtask

   task automatic pipe(input logic we, input logic [4:0] a,
                       input logic [31:0] wd);
      pipe_we = we;
      pipe_a3 = a;
      pipe_wd = wd;
      pipe_pc = 32'h4000 + wd;
   endtask

   initial begin
      n_vec = 0;
      n_err = 0;
      reset = 1'b1;
      rd_a1 = '0;
      rd_a2 = '0;
      aux(1'b0, 5'd0);
      pipe(1'b0, 5'd0, 32'h0);

      // reset state
      tick();
      pipe(1'b1, 5'd4, 32'h44);
      aux(1'b1, 5'd5);
      tick();
      chk("rst_ready", aux_ready, 0);
      chk("rst_a3", grf_a3, 0);
      chk("rst_wd", grf_wd, 0);
      chk("rst_stall", stall_req, 0);
      chk("rst_cnt", fifo_cnt, 0);
      pipe(1'b0, 5'd0, 32'h0);
      aux(1'b0, 5'd0);
      reset = 1'b0;
      #1;
      chk("rel_cnt", fifo_cnt, 0);
      chk("rel_ready", aux_ready, 1);

      // 1: three aux words drain back-to-back
      aux(1'b1, 5'd5);
      #1;
      chk("s1_idle_a3", grf_a3, 0);
      tick();
      aux(1'b1, 5'd6);
      #1;
      chk("s1_a3_5", grf_a3, 5);
      chk("s1_wd_5", grf_wd, 32'h105);
      chk("s1_pc_5", grf_pc, 32'h1014);
      chk("s1_cnt", fifo_cnt, 1);
      tick();
      aux(1'b1, 5'd7);
      #1;
      chk("s1_a3_6", grf_a3, 6);
      tick();
      aux(1'b0, 5'd0);
      #1;
      chk("s1_a3_7", grf_a3, 7);
      tick();
      chk("s1_end_cnt", fifo_cnt, 0);
      chk("s1_end_a3", grf_a3, 0);

      // aux to r0 is accepted and dropped
      aux(1'b1, 5'd0);
      #1;
      chk("r0_ready", aux_ready, 1);
      tick();
      aux(1'b0, 5'd0);
      #1;
      chk("r0_cnt", fifo_cnt, 0);
      chk("r0_a3", grf_a3, 0);

      // 2: fill under pipe pressure, full back-pressure
      pipe(1'b1, 5'd3, 32'h33);
      for (int i = 0; i < 4; i++) begin
         aux(1'b1, 5'(10 + i));
         #1;
         chk("s2_ready", aux_ready, 1);
         chk("s2_cnt", fifo_cnt, 32'(i));
         chk("s2_pipe_a3", grf_a3, 3);
         chk("s2_pipe_wd", grf_wd, 32'h33);
         tick();
      end
      aux(1'b1, 5'd14);
      #1;
      chk("s2_full_ready", aux_ready, 0);
      chk("s2_full_cnt", fifo_cnt, 4);
      tick();
      chk("s2_held_cnt", fifo_cnt, 4);
      pipe(1'b0, 5'd0, 32'h0);
      #1;
      chk("s2_pop10", grf_a3, 10);
      chk("s2_nopass", aux_ready, 0);
      tick();
      chk("s2_cnt3", fifo_cnt, 3);
      chk("s2_ready3", aux_ready, 1);
      chk("s2_pop11", grf_a3, 11);
      tick();
      aux(1'b0, 5'd0);
      #1;
      chk("s2_cnt3b", fifo_cnt, 3);
      chk("s2_pop12", grf_a3, 12);
      tick();
      chk("s2_pop13", grf_a3, 13);
      tick();
      chk("s2_pop14", grf_a3, 14);
      chk("s2_wd14", grf_wd, 32'h10e);
      tick();
      chk("s2_empty", fifo_cnt, 0);

      // 3: WAW kill of a queued aux write
      pipe(1'b1, 5'd3, 32'h33);
      aux(1'b1, 5'd8);
      tick();
      aux(1'b0, 5'd0);
      pipe(1'b1, 5'd8, 32'h88);
      rd_a1 = 5'd8;
      #1;
      chk("s3_pend_pre", pend_hit1, 1);
      chk("s3_pipe_a3", grf_a3, 8);
      chk("s3_pipe_wd", grf_wd, 32'h88);
      tick();
      pipe(1'b1, 5'd3, 32'h33);
      #1;
      chk("s3_pend_kill", pend_hit1, 0);
      chk("s3_cnt", fifo_cnt, 1);
      tick();
      pipe(1'b0, 5'd0, 32'h0);
      rd_a1 = 5'd0;
      #1;
      chk("s3_killed_a3", grf_a3, 0);
      tick();
      chk("s3_cnt0", fifo_cnt, 0);

      // 4: starvation raises stall_req after 8 blocked cycles
      pipe(1'b1, 5'd3, 32'h33);
      aux(1'b1, 5'd20);
      tick();
      aux(1'b0, 5'd0);
      for (int j = 1; j <= 8; j++) begin
         #1;
         chk("s4_nostall", stall_req, 0);
         tick();
      end
      chk("s4_stall", stall_req, 1);
      chk("s4_cnt", fifo_cnt, 1);
      pipe(1'b0, 5'd0, 32'h0);
      #1;
      chk("s4_pop20", grf_a3, 20);
      tick();
      chk("s4_stall_clr", stall_req, 0);
      chk("s4_cnt0", fifo_cnt, 0);

      // 5: pending hits; same-edge enqueue is younger than pipe write
      pipe(1'b1, 5'd9, 32'h99);
      aux(1'b1, 5'd9);
      rd_a1 = 5'd9;
      rd_a2 = 5'd0;
      #1;
      chk("s5_pend_enq", pend_hit1, 0);
      tick();
      pipe(1'b1, 5'd3, 32'h33);
      aux(1'b0, 5'd0);
      #1;
      chk("s5_pend1", pend_hit1, 1);
      chk("s5_pend2_r0", pend_hit2, 0);
      rd_a2 = 5'd9;
      #1;
      chk("s5_pend2", pend_hit2, 1);
      rd_a2 = 5'd0;
      tick();
      pipe(1'b0, 5'd0, 32'h0);
      #1;
      chk("s5_pop9", grf_a3, 9);
      chk("s5_wd9", grf_wd, 32'h109);
      tick();
      chk("s5_pend_gone", pend_hit1, 0);
      rd_a1 = 5'd0;

      // 6: reset discards queued entries
      pipe(1'b1, 5'd3, 32'h33);
      for (int i = 0; i < 3; i++) begin
         aux(1'b1, 5'(21 + i));
         tick();
      end
      aux(1'b0, 5'd0);
      #1;
      chk("s6_cnt3", fifo_cnt, 3);
      reset = 1'b1;
      pipe(1'b0, 5'd0, 32'h0);
      #1;
      chk("s6_rst_a3", grf_a3, 0);
      chk("s6_rst_ready", aux_ready, 0);
      tick();
      reset = 1'b0;
      #1;
      chk("s6_cnt0", fifo_cnt, 0);
      chk("s6_a3_0", grf_a3, 0);
      tick();
      chk("s6_a3_1", grf_a3, 0);
      chk("s6_cnt1", fifo_cnt, 0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
